// File: rtl/lmem_pkg.sv
// rtl/lmem_pkg.sv - shared encodings and widths for the local memory arbiter
package lmem_pkg;

  typedef logic [1:0] owner_t;

  localparam owner_t OWN_IDLE = 2'd0;
  localparam owner_t OWN_A    = 2'd1;
  localparam owner_t OWN_B    = 2'd2;

  localparam logic ID_A = 1'b0;
  localparam logic ID_B = 1'b1;

  localparam int LMEM_AW = 10;
  localparam int LMEM_DW = 32;

  // Burst counter width; a burst of one still needs a 1-bit counter.
  function automatic int cnt_width(input int max_burst);
    return (max_burst <= 1) ? 1 : $clog2(max_burst);
  endfunction

endpackage

// File: rtl/lmem_rd_pipe.sv
// rtl/lmem_rd_pipe.sv - RD_LAT-deep {vld,id} shift register tracking reads in flight
module lmem_rd_pipe #(
  parameter int RD_LAT = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push_vld,
  input  logic push_id,
  output logic tail_vld,
  output logic tail_id
);

  logic [RD_LAT-1:0] vld_q;
  logic [RD_LAT-1:0] id_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      id_q  <= '0;
    end else begin
      vld_q[0] <= push_vld;
      id_q[0]  <= push_id;
      for (int i = RD_LAT - 1; i > 0; i--) begin
        vld_q[i] <= vld_q[i-1];
        id_q[i]  <= id_q[i-1];
      end
    end
  end

  assign tail_vld = vld_q[RD_LAT-1];
  assign tail_id  = id_q[RD_LAT-1];

endmodule

// File: rtl/local_mem_arbiter.sv
// rtl/local_mem_arbiter.sv - round-robin, burst-bounded sharing of the local memory by RX (A) and TX (B)
module local_mem_arbiter
  import lmem_pkg::*;
#(
  parameter int MAX_BURST = 16,
  parameter int RD_LAT    = 1,
  parameter int AW        = LMEM_AW,
  parameter int DW        = LMEM_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_din,
  output logic          a_gnt,
  output logic          a_rd_vld,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_din,
  output logic          b_gnt,
  output logic          b_rd_vld,
  output logic [DW-1:0] rd_data,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout
);

  localparam int            CW       = cnt_width(MAX_BURST);
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BURST - 1);

  owner_t        owner_q, owner_d;
  logic          last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic accept;
  logic push_vld;
  logic push_id;
  logic tail_vld;
  logic tail_id;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q <= OWN_IDLE;
      last_q  <= ID_B;
      cnt_q   <= '0;
    end else begin
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  // An owner that keeps requesting holds every cycle, so each held cycle is an accepted beat.
  always_comb begin
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (owner_q)
      OWN_IDLE: begin
        if (a_req && (!b_req || last_q == ID_B)) owner_d = OWN_A;
        else if (b_req)                          owner_d = OWN_B;
      end
      OWN_A: begin
        if (!a_req) begin
          owner_d = b_req ? OWN_B : OWN_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (b_req) owner_d = OWN_B;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      OWN_B: begin
        if (!b_req) begin
          owner_d = a_req ? OWN_A : OWN_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (a_req) owner_d = OWN_A;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: owner_d = OWN_IDLE;
    endcase
    if (owner_d != owner_q) begin
      cnt_d = '0;
      if (owner_q == OWN_A)      last_d = ID_A;
      else if (owner_q == OWN_B) last_d = ID_B;
    end
  end

  always_comb begin
    a_gnt    = (owner_q == OWN_A);
    b_gnt    = (owner_q == OWN_B);
    accept   = (a_gnt && a_req) || (b_gnt && b_req);
    mem_addr = a_gnt ? a_addr : b_addr;
    mem_din  = a_gnt ? a_din  : b_din;
    mem_we   = accept && (a_gnt ? a_we : b_we);
    push_vld = accept && !(a_gnt ? a_we : b_we);
    push_id  = b_gnt ? ID_B : ID_A;
  end

  lmem_rd_pipe #(
    .RD_LAT (RD_LAT)
  ) u_rd_pipe (
    .clk      (clk),
    .rst_n    (rst_n),
    .push_vld (push_vld),
    .push_id  (push_id),
    .tail_vld (tail_vld),
    .tail_id  (tail_id)
  );

  assign a_rd_vld = tail_vld && (tail_id == ID_A);
  assign b_rd_vld = tail_vld && (tail_id == ID_B);
  assign rd_data  = mem_dout;

endmodule

// File: tb/tb_local_mem_arbiter.sv
// tb/tb_local_mem_arbiter.sv - directed self-checking bench for local_mem_arbiter
module tb_local_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_req, a_we, b_req, b_we;
  logic [9:0]  a_addr, b_addr;
  logic [31:0] a_din, b_din;
  logic        a_gnt, a_rd_vld, b_gnt, b_rd_vld;
  logic [31:0] rd_data;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_din;
  logic [31:0] mem_dout = '0;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Memory model: one-cycle read latency, returns {addr+1, addr} as 16-bit halves.
  always @(posedge clk) mem_dout <= {({6'b0, mem_addr} + 16'd1), {6'b0, mem_addr}};

  local_mem_arbiter #(
    .MAX_BURST (4),
    .RD_LAT    (1),
    .AW        (10),
    .DW        (32)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .a_req    (a_req),
    .a_we     (a_we),
    .a_addr   (a_addr),
    .a_din    (a_din),
    .a_gnt    (a_gnt),
    .a_rd_vld (a_rd_vld),
    .b_req    (b_req),
    .b_we     (b_we),
    .b_addr   (b_addr),
    .b_din    (b_din),
    .b_gnt    (b_gnt),
    .b_rd_vld (b_rd_vld),
    .rd_data  (rd_data),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_din  (mem_din),
    .mem_dout (mem_dout)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_din = '0;
    b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_din = '0;

    // 1: reset holds everything quiet regardless of requests
    for (int i = 0; i < 4; i++) begin
      a_req = 1'($urandom); a_we = 1'($urandom);
      b_req = 1'($urandom); b_we = 1'($urandom);
      tick();
      chk("rst_a_gnt", a_gnt, 0);
      chk("rst_b_gnt", b_gnt, 0);
      chk("rst_a_rd_vld", a_rd_vld, 0);
      chk("rst_b_rd_vld", b_rd_vld, 0);
      chk("rst_mem_we", mem_we, 0);
    end
    rst_n = 1'b1;
    a_req = 1'b1; a_we = 1'b1; a_addr = 10'h010; a_din = 32'hA000_0000;
    b_req = 1'b0; b_we = 1'b0;
    #1;
    chk("rel_bubble_a_gnt", a_gnt, 0);
    tick();
    chk("rel_a_gnt", a_gnt, 1);

    // 2: four-beat write burst from A, then A drops to IDLE
    for (int i = 0; i < 4; i++) begin
      a_addr = 10'h010 + 10'(i);
      a_din  = 32'hA000_0000 + 32'(i);
      #1;
      chk("wr_mem_we", mem_we, 1);
      chk("wr_mem_addr", 32'(mem_addr), 32'h010 + 32'(i));
      chk("wr_mem_din", mem_din, 32'hA000_0000 + 32'(i));
      tick();
    end
    a_req = 1'b0;
    #1;
    chk("wr_done_mem_we", mem_we, 0);
    tick();
    chk("wr_idle_a_gnt", a_gnt, 0);
    chk("wr_idle_b_gnt", b_gnt, 0);

    // 3: tie from a fresh reset alternates A x4, B x4, A x4 with no bubble
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    a_req = 1'b1; a_we = 1'b1; a_addr = 10'h040;
    b_req = 1'b1; b_we = 1'b1; b_addr = 10'h080;
    tick();
    for (int i = 0; i < 12; i++) begin
      chk("tie_a_gnt", a_gnt, ((i / 4) % 2 == 0) ? 1 : 0);
      chk("tie_b_gnt", b_gnt, ((i / 4) % 2 == 1) ? 1 : 0);
      tick();
    end
    chk("tie_next_b_gnt", b_gnt, 1);
    a_req = 1'b0; b_req = 1'b0;
    tick();
    chk("tie_idle_b_gnt", b_gnt, 0);

    // 4: single read by B returns one cycle after acceptance
    b_req = 1'b1; b_we = 1'b0; b_addr = 10'h005;
    tick();
    chk("rd_b_gnt", b_gnt, 1);
    chk("rd_mem_we", mem_we, 0);
    chk("rd_mem_addr", 32'(mem_addr), 32'h005);
    tick();
    chk("rd_b_rd_vld", b_rd_vld, 1);
    chk("rd_a_rd_vld", a_rd_vld, 0);
    chk("rd_data", rd_data, 32'h0006_0005);
    b_req = 1'b0;
    tick();
    chk("rd_b_rd_vld_off", b_rd_vld, 0);

    // 5: A reads on its last beat, return lands while B owns memory
    a_req = 1'b1; a_we = 1'b1; a_addr = 10'h100;
    b_req = 1'b1; b_we = 1'b1; b_addr = 10'h200;
    tick();
    chk("ho_a_gnt", a_gnt, 1);
    for (int i = 0; i < 3; i++) begin
      a_addr = 10'h100 + 10'(i);
      tick();
    end
    a_we = 1'b0; a_addr = 10'h3FF;
    #1;
    chk("ho_rd_mem_we", mem_we, 0);
    chk("ho_rd_mem_addr", 32'(mem_addr), 32'h3FF);
    tick();
    chk("ho_b_gnt", b_gnt, 1);
    chk("ho_a_gnt_off", a_gnt, 0);
    chk("ho_a_rd_vld", a_rd_vld, 1);
    chk("ho_b_rd_vld", b_rd_vld, 0);
    chk("ho_rd_data", rd_data, 32'h0400_03FF);
    chk("ho_mem_addr_b", 32'(mem_addr), 32'h200);
    a_req = 1'b0; b_req = 1'b0;
    tick();
    chk("ho_a_rd_vld_off", a_rd_vld, 0);

    // 6: reset right after an accepted read flushes the return
    a_req = 1'b1; a_we = 1'b0; a_addr = 10'h020;
    tick();
    chk("rr_a_gnt", a_gnt, 1);
    tick();
    rst_n = 1'b0;
    a_req = 1'b0;
    #1;
    chk("rr_flush_a_rd_vld", a_rd_vld, 0);
    chk("rr_flush_a_gnt", a_gnt, 0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rr_post_a_rd_vld", a_rd_vld, 0);
      chk("rr_post_b_rd_vld", b_rd_vld, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
